// File: rtl/siphash_core_gen_if.sv
// Command/result bundle for the SipHash core: commands, key/message inputs,
// digest outputs.
interface siphash_core_gen_if;
  logic         initalize;
  logic         compress;
  logic         finalize;
  logic         long;
  logic [3:0]   compression_rounds;
  logic [3:0]   final_rounds;
  logic [127:0] key;
  logic [63:0]  mi;
  logic         ready;
  logic [127:0] siphash_word;
  logic         siphash_word_valid;

  modport master (
    output initalize, compress, finalize, long, compression_rounds, final_rounds, key, mi,
    input  ready, siphash_word, siphash_word_valid
  );
  modport slave (
    input  initalize, compress, finalize, long, compression_rounds, final_rounds, key, mi,
    output ready, siphash_word, siphash_word_valid
  );
endinterface

// File: rtl/siphash_core_gen.sv
// SipHash-64/128 core, 1 or 2 SipRounds per clock, with configurable c/d rounds
// and the 0xdd second finalisation pass in long mode.
module siphash_core_gen #(
  parameter int UNROLL       = 1,
  parameter bit DEFAULT_LONG = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  siphash_core_gen_if.slave  bus
);
  if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
    $error("siphash_core_gen: UNROLL must be 1 or 2");
  end

  typedef logic [3:0][63:0] vstate_t;
  typedef enum logic [2:0] {IDLE, COMP_LOOP, COMP_END, FINAL_LOOP, FINAL_MID, FINAL_END} fsm_t;

  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic vstate_t sipround(input vstate_t s);
    logic [63:0] a, b, e, f;
    a = s[0]; b = s[1]; e = s[2]; f = s[3];
    a = a + b; b = rotl(b, 13); b = b ^ a; a = rotl(a, 32);
    e = e + f; f = rotl(f, 16); f = f ^ e;
    a = a + f; f = rotl(f, 21); f = f ^ a;
    e = e + b; b = rotl(b, 17); b = b ^ e; e = rotl(e, 32);
    return {f, e, b, a};
  endfunction

  fsm_t        state, state_n;
  vstate_t     v, v_n, r1, r2;
  logic [63:0] mi_reg, mi_n, word0, word0_n, word1, word1_n, vxor;
  logic [4:0]  counter, counter_n, rounds, remaining;
  logic        long_reg, long_n, valid, valid_n, pass, pass_n, two;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      v        <= '0;
      mi_reg   <= '0;
      word0    <= '0;
      word1    <= '0;
      counter  <= '0;
      long_reg <= DEFAULT_LONG;
      valid    <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state    <= state_n;
      v        <= v_n;
      mi_reg   <= mi_n;
      word0    <= word0_n;
      word1    <= word1_n;
      counter  <= counter_n;
      long_reg <= long_n;
      valid    <= valid_n;
      pass     <= pass_n;
    end
  end

  // Second chained round is only taken when at least two rounds remain.
  assign r1        = sipround(v);
  assign r2        = sipround(r1);
  assign rounds    = {1'b0, (state == COMP_LOOP) ? bus.compression_rounds : bus.final_rounds};
  assign remaining = rounds - counter;
  assign two       = (UNROLL == 2) && (remaining >= 5'd2);
  assign vxor      = v[0] ^ v[1] ^ v[2] ^ v[3];

  always_comb begin
    state_n   = state;
    v_n       = v;
    mi_n      = mi_reg;
    word0_n   = word0;
    word1_n   = word1;
    counter_n = counter;
    long_n    = long_reg;
    valid_n   = valid;
    pass_n    = pass;
    case (state)
      IDLE: begin
        if (bus.initalize) begin
          v_n[0]  = bus.key[63:0]   ^ 64'h736f6d6570736575;
          v_n[1]  = bus.key[127:64] ^ 64'h646f72616e646f6d ^ (bus.long ? 64'hee : 64'h0);
          v_n[2]  = bus.key[63:0]   ^ 64'h6c7967656e657261;
          v_n[3]  = bus.key[127:64] ^ 64'h7465646279746573;
          long_n  = bus.long;
          valid_n = 1'b0;
        end else if (bus.compress) begin
          v_n[3]    = v[3] ^ bus.mi;
          mi_n      = bus.mi;
          counter_n = '0;
          state_n   = (bus.compression_rounds != 4'd0) ? COMP_LOOP : COMP_END;
        end else if (bus.finalize) begin
          v_n[2]    = v[2] ^ (long_reg ? 64'hee : 64'hff);
          counter_n = '0;
          valid_n   = 1'b0;
          pass_n    = 1'b0;
          if (bus.final_rounds != 4'd0) state_n = FINAL_LOOP;
          else                          state_n = long_reg ? FINAL_MID : FINAL_END;
        end
      end
      COMP_LOOP: begin
        v_n       = two ? r2 : r1;
        counter_n = counter + (two ? 5'd2 : 5'd1);
        if (counter_n >= rounds) state_n = COMP_END;
      end
      COMP_END: begin
        v_n[0]  = v[0] ^ mi_reg;
        state_n = IDLE;
      end
      FINAL_LOOP: begin
        v_n       = two ? r2 : r1;
        counter_n = counter + (two ? 5'd2 : 5'd1);
        if (counter_n >= rounds) state_n = (long_reg && !pass) ? FINAL_MID : FINAL_END;
      end
      FINAL_MID: begin
        word0_n   = vxor;
        v_n[1]    = v[1] ^ 64'hdd;
        counter_n = '0;
        pass_n    = 1'b1;
        state_n   = (bus.final_rounds != 4'd0) ? FINAL_LOOP : FINAL_END;
      end
      FINAL_END: begin
        if (long_reg) word1_n = vxor;
        else begin
          word0_n = vxor;
          word1_n = '0;
        end
        valid_n = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ready              = (state == IDLE);
  assign bus.siphash_word       = {word1, word0};
  assign bus.siphash_word_valid = valid;
endmodule

// File: tb/tb_siphash_core_gen.sv
// Directed checks of siphash_core_gen with UNROLL=1 and UNROLL=2 instances
// driven in lockstep: reference digests, latencies, command filtering, reset.
module tb_siphash_core_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   ntot = 0;
  int   npass = 0;

  always #5 clk = ~clk;

  siphash_core_gen_if b1 ();
  siphash_core_gen_if b2 ();

  assign b2.initalize          = b1.initalize;
  assign b2.compress           = b1.compress;
  assign b2.finalize           = b1.finalize;
  assign b2.long               = b1.long;
  assign b2.compression_rounds = b1.compression_rounds;
  assign b2.final_rounds       = b1.final_rounds;
  assign b2.key                = b1.key;
  assign b2.mi                 = b1.mi;

  siphash_core_gen #(.UNROLL(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  siphash_core_gen #(.UNROLL(2)) u2 (.clk(clk), .reset(reset), .bus(b2));

  localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // which: 0 init, 1 compress, 2 finalize, 3 all three at once
  task automatic pulse(input int which, output int l1, output int l2);
    @(negedge clk);
    b1.initalize = (which == 0 || which == 3);
    b1.compress  = (which == 1 || which == 3);
    b1.finalize  = (which == 2 || which == 3);
    @(negedge clk);
    b1.initalize = 1'b0;
    b1.compress  = 1'b0;
    b1.finalize  = 1'b0;
    l1 = 0;
    l2 = 0;
    for (int i = 0; i < 64; i++) begin
      if (!b1.ready) l1++;
      if (!b2.ready) l2++;
      if (b1.ready && b2.ready) break;
      @(negedge clk);
    end
  endtask

  function automatic logic [63:0] rl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [255:0] rnd(input logic [255:0] s);
    logic [63:0] a, b, e, f;
    {f, e, b, a} = s;
    a += b; b = rl(b, 13) ^ a; a = rl(a, 32);
    e += f; f = rl(f, 16) ^ e;
    a += f; f = rl(f, 21) ^ a;
    e += b; b = rl(b, 17) ^ e; e = rl(e, 32);
    return {f, e, b, a};
  endfunction

  function automatic logic [127:0] ref_hash(input logic [127:0] k, input logic [63:0] m [8],
                                            input int n, input int c, input int d, input bit lng);
    logic [63:0] v0, v1, v2, v3, w0;
    v0 = k[63:0]   ^ 64'h736f6d6570736575;
    v1 = k[127:64] ^ 64'h646f72616e646f6d ^ (lng ? 64'hee : 64'h0);
    v2 = k[63:0]   ^ 64'h6c7967656e657261;
    v3 = k[127:64] ^ 64'h7465646279746573;
    for (int i = 0; i < n; i++) begin
      v3 ^= m[i];
      for (int r = 0; r < c; r++) {v3, v2, v1, v0} = rnd({v3, v2, v1, v0});
      v0 ^= m[i];
    end
    v2 ^= lng ? 64'hee : 64'hff;
    for (int r = 0; r < d; r++) {v3, v2, v1, v0} = rnd({v3, v2, v1, v0});
    w0 = v0 ^ v1 ^ v2 ^ v3;
    if (!lng) return {64'h0, w0};
    v1 ^= 64'hdd;
    for (int r = 0; r < d; r++) {v3, v2, v1, v0} = rnd({v3, v2, v1, v0});
    return {v0 ^ v1 ^ v2 ^ v3, w0};
  endfunction

  initial begin
    int l1, l2, n;
    logic [63:0]  m [8];
    logic [127:0] exp;
    b1.initalize = 0; b1.compress = 0; b1.finalize = 0; b1.long = 0;
    b1.compression_rounds = 4'd2; b1.final_rounds = 4'd4;
    b1.key = KEY; b1.mi = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready1", {127'h0, b1.ready}, 128'h1);
    chk("rst_valid1", {127'h0, b1.siphash_word_valid}, 128'h0);
    chk("rst_word1", b1.siphash_word, 128'h0);
    chk("rst_ready2", {127'h0, b2.ready}, 128'h1);
    chk("rst_word2", b2.siphash_word, 128'h0);
    reset = 1'b0;

    // SipHash-2-4, empty message, 64-bit
    pulse(0, l1, l2);
    chk("init_lat", {l1[31:0], l2[31:0]}, {32'd0, 32'd0});
    pulse(1, l1, l2);
    chk("c2_lat", {l1[31:0], l2[31:0]}, {32'd3, 32'd2});
    pulse(2, l1, l2);
    chk("d4_lat", {l1[31:0], l2[31:0]}, {32'd5, 32'd3});
    chk("sh64_u1", b1.siphash_word, {64'h0, 64'h726fdb47dd0e0e31});
    chk("sh64_u2", b2.siphash_word, {64'h0, 64'h726fdb47dd0e0e31});
    chk("sh64_valid", {b1.siphash_word_valid, b2.siphash_word_valid}, 128'h3);

    // SipHash-2-4, empty message, 128-bit
    b1.long = 1'b1;
    pulse(0, l1, l2);
    chk("init_clears_valid", {b1.siphash_word_valid, b2.siphash_word_valid}, 128'h0);
    pulse(1, l1, l2);
    pulse(2, l1, l2);
    chk("long_d4_lat", {l1[31:0], l2[31:0]}, {32'd10, 32'd6});
    chk("sh128_u1", b1.siphash_word, 128'h930255c71472f66d_e6a825ba047f81a3);
    chk("sh128_u2", b2.siphash_word, 128'h930255c71472f66d_e6a825ba047f81a3);

    // SipHash-3-5 against the reference over random keys/messages
    b1.compression_rounds = 4'd3;
    b1.final_rounds = 4'd5;
    for (int t = 0; t < 6; t++) begin
      b1.key  = {$urandom, $urandom, $urandom, $urandom};
      b1.long = t[0];
      n = 1 + (t % 4);
      pulse(0, l1, l2);
      for (int i = 0; i < n; i++) begin
        m[i] = {$urandom, $urandom};
        b1.mi = m[i];
        pulse(1, l1, l2);
        chk("c3_lat", {l1[31:0], l2[31:0]}, {32'd4, 32'd3});
      end
      pulse(2, l1, l2);
      chk("d5_lat", {l1[31:0], l2[31:0]}, t[0] ? {32'd12, 32'd8} : {32'd6, 32'd4});
      exp = ref_hash(b1.key, m, n, 3, 5, t[0]);
      chk("sh35_u1", b1.siphash_word, exp);
      chk("sh35_u2", b2.siphash_word, exp);
    end

    // Zero rounds: result is key-independent constant XOR
    b1.compression_rounds = 4'd0;
    b1.final_rounds = 4'd0;
    b1.long = 1'b0;
    b1.mi = 64'h1234_5678_9abc_def0;
    pulse(0, l1, l2);
    pulse(1, l1, l2);
    chk("c0_lat", {l1[31:0], l2[31:0]}, {32'd1, 32'd1});
    pulse(2, l1, l2);
    chk("d0_lat", {l1[31:0], l2[31:0]}, {32'd1, 32'd1});
    chk("d0_u1", b1.siphash_word, {64'h0, 64'h0f1c1c0309061df5});
    chk("d0_u2", b2.siphash_word, {64'h0, 64'h0f1c1c0309061df5});
    b1.long = 1'b1;
    pulse(0, l1, l2);
    pulse(1, l1, l2);
    pulse(2, l1, l2);
    chk("long_d0_lat", {l1[31:0], l2[31:0]}, {32'd2, 32'd2});
    chk("long_d0_u1", b1.siphash_word, 128'h0f1c1c0309061dd7_0f1c1c0309061d0a);
    chk("long_d0_u2", b2.siphash_word, 128'h0f1c1c0309061dd7_0f1c1c0309061d0a);

    // Compress pulse while busy is dropped
    b1.key = KEY; b1.long = 1'b0; b1.mi = '0;
    b1.compression_rounds = 4'd2; b1.final_rounds = 4'd4;
    pulse(0, l1, l2);
    pulse(1, l1, l2);
    @(negedge clk); b1.finalize = 1'b1;
    @(negedge clk); b1.finalize = 1'b0; b1.compress = 1'b1; b1.mi = 64'hdead_beef;
    @(negedge clk); b1.compress = 1'b0; b1.mi = '0;
    for (int i = 0; i < 64 && !(b1.ready && b2.ready); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("busy_ignored_u1", b1.siphash_word, {64'h0, 64'h726fdb47dd0e0e31});
    chk("busy_ignored_u2", b2.siphash_word, {64'h0, 64'h726fdb47dd0e0e31});

    // Init+compress+finalize together: only init acts
    b1.mi = 64'h5555_aaaa_5555_aaaa;
    pulse(3, l1, l2);
    chk("prio_lat", {l1[31:0], l2[31:0]}, {32'd0, 32'd0});
    chk("prio_valid", {b1.siphash_word_valid, b2.siphash_word_valid}, 128'h0);
    b1.mi = '0;
    pulse(1, l1, l2);
    pulse(2, l1, l2);
    chk("prio_digest", {b1.siphash_word[63:0], b2.siphash_word[63:0]},
        {64'h726fdb47dd0e0e31, 64'h726fdb47dd0e0e31});

    // Reset in the middle of FINAL_LOOP
    b1.final_rounds = 4'd15;
    pulse(0, l1, l2);
    pulse(1, l1, l2);
    @(negedge clk); b1.finalize = 1'b1;
    @(negedge clk); b1.finalize = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("midrst_ready", {b1.ready, b2.ready}, 128'h3);
    chk("midrst_valid", {b1.siphash_word_valid, b2.siphash_word_valid}, 128'h0);
    chk("midrst_word", b1.siphash_word | b2.siphash_word, 128'h0);
    reset = 1'b0;
    b1.final_rounds = 4'd4;
    pulse(0, l1, l2);
    pulse(1, l1, l2);
    pulse(2, l1, l2);
    chk("postrst_u1", b1.siphash_word, {64'h0, 64'h726fdb47dd0e0e31});
    chk("postrst_u2", b2.siphash_word, {64'h0, 64'h726fdb47dd0e0e31});

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
